// File: rtl/cache_fill_responder_if.sv
// Bundle between cache_fill_responder (slave) and its environment (master):
// the I/D cache controllers on one side and main memory on the other.
interface cache_fill_responder_if #(
  parameter int WORDS_PER_BLOCK = 8
);
  localparam int IDX_W = $clog2(WORDS_PER_BLOCK);

  logic             i_miss;
  logic [15:0]      i_addr;
  logic             d_miss;
  logic [15:0]      d_addr;
  logic             d_store;
  logic [15:0]      d_wdata;
  logic [15:0]      mem_addr;
  logic             mem_enable;
  logic             mem_wr;
  logic [15:0]      mem_data_in;
  logic [15:0]      mem_data_out;
  logic             mem_data_valid;
  logic [15:0]      fill_data;
  logic [IDX_W-1:0] word_num;
  logic             i_write_data;
  logic             i_write_tag;
  logic             d_write_data;
  logic             d_write_tag;
  logic             d_store_done;
  logic             busy;

  modport slave (
    input  i_miss, i_addr, d_miss, d_addr, d_store, d_wdata,
    input  mem_data_out, mem_data_valid,
    output mem_addr, mem_enable, mem_wr, mem_data_in,
    output fill_data, word_num, i_write_data, i_write_tag,
    output d_write_data, d_write_tag, d_store_done, busy
  );

  modport master (
    output i_miss, i_addr, d_miss, d_addr, d_store, d_wdata,
    output mem_data_out, mem_data_valid,
    input  mem_addr, mem_enable, mem_wr, mem_data_in,
    input  fill_data, word_num, i_write_data, i_write_tag,
    input  d_write_data, d_write_tag, d_store_done, busy
  );
endinterface

// File: rtl/cache_fill_responder.sv
// Block-fill / write-through responder shared by the I- and D-cache controllers.
// Optional macro FILL_PERF_CNT_EN adds saturating per-side fill counters.
module cache_fill_responder #(
  parameter int WORDS_PER_BLOCK = 8
) (
  input  logic clk,
  input  logic rst,
  cache_fill_responder_if.slave bus
`ifdef FILL_PERF_CNT_EN
  ,
  output logic [15:0] i_fill_cnt,
  output logic [15:0] d_fill_cnt
`endif
);

  localparam int               IDX_W     = $clog2(WORDS_PER_BLOCK);
  localparam int               CNT_W     = IDX_W + 1;
  localparam logic [15:0]      BASE_MASK = ~16'(2 * WORDS_PER_BLOCK - 1);
  localparam logic [CNT_W-1:0] N_WORDS   = CNT_W'(WORDS_PER_BLOCK);
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS_PER_BLOCK - 1);

  typedef enum logic [1:0] {IDLE, FILL, TAG, STORE} state_t;

  state_t           state;
  logic             src_d;
  logic [15:0]      base;
  logic [CNT_W-1:0] issue_cnt;
  logic [CNT_W-1:0] recv_cnt;
  logic             take_word;
  logic [15:0]      miss_base;
  logic [15:0]      issue_off;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Returns are only meaningful while filling; anything else is a stale beat.
  assign take_word        = (state == FILL) && bus.mem_data_valid;
  assign bus.fill_data    = take_word ? bus.mem_data_out : '0;
  assign bus.word_num     = take_word ? recv_cnt[IDX_W-1:0] : '0;
  assign bus.i_write_data = take_word && !src_d;
  assign bus.d_write_data = take_word && src_d;
  assign bus.busy         = (state != IDLE);

  assign miss_base = (bus.d_miss ? bus.d_addr : bus.i_addr) & BASE_MASK;
  assign issue_off = 16'(issue_cnt[IDX_W-1:0]) << 1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      src_d            <= 1'b0;
      base             <= '0;
      issue_cnt        <= '0;
      recv_cnt         <= '0;
      bus.mem_addr     <= '0;
      bus.mem_enable   <= 1'b0;
      bus.mem_wr       <= 1'b0;
      bus.mem_data_in  <= '0;
      bus.i_write_tag  <= 1'b0;
      bus.d_write_tag  <= 1'b0;
      bus.d_store_done <= 1'b0;
    end else begin
      bus.mem_addr     <= '0;
      bus.mem_enable   <= 1'b0;
      bus.mem_wr       <= 1'b0;
      bus.mem_data_in  <= '0;
      bus.i_write_tag  <= 1'b0;
      bus.d_write_tag  <= 1'b0;
      bus.d_store_done <= 1'b0;
      case (state)
        IDLE: begin
          // A store only goes ahead when no D miss competes for d_addr.
          if (bus.d_store && !bus.d_miss) begin
            state            <= STORE;
            bus.mem_enable   <= 1'b1;
            bus.mem_wr       <= 1'b1;
            bus.mem_addr     <= bus.d_addr;
            bus.mem_data_in  <= bus.d_wdata;
            bus.d_store_done <= 1'b1;
          end else if (bus.d_miss || bus.i_miss) begin
            state          <= FILL;
            src_d          <= bus.d_miss;
            base           <= miss_base;
            bus.mem_enable <= 1'b1;
            bus.mem_addr   <= miss_base;
            issue_cnt      <= CNT_W'(1);
            recv_cnt       <= '0;
          end
        end
        FILL: begin
          // Reads are issued back-to-back; returns are counted independently.
          if (issue_cnt < N_WORDS) begin
            bus.mem_enable <= 1'b1;
            bus.mem_addr   <= base + issue_off;
            issue_cnt      <= issue_cnt + CNT_W'(1);
          end
          if (take_word) begin
            recv_cnt <= recv_cnt + CNT_W'(1);
            if (recv_cnt == LAST_WORD) begin
              state           <= TAG;
              bus.i_write_tag <= !src_d;
              bus.d_write_tag <= src_d;
            end
          end
        end
        TAG:     state <= IDLE;
        STORE:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FILL_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      i_fill_cnt <= '0;
      d_fill_cnt <= '0;
    end else if (state == TAG) begin
      if (src_d) d_fill_cnt <= sat_inc16(d_fill_cnt);
      else       i_fill_cnt <= sat_inc16(i_fill_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_cache_fill_responder.sv
// Directed plus random stimulus for cache_fill_responder, checked cycle by cycle
// against a transaction-level timeline model and a fixed-latency memory.
module tb_cache_fill_responder;

  localparam int W           = 8;
  localparam int MEM_LATENCY = 4;
  localparam int RING        = 64;

  typedef struct packed {
    logic [15:0] mem_addr;
    logic        mem_enable;
    logic        mem_wr;
    logic [15:0] mem_data_in;
    logic [15:0] fill_data;
    logic [2:0]  word_num;
    logic        iwd;
    logic        iwt;
    logic        dwd;
    logic        dwt;
    logic        sdone;
    logic        busy;
  } ov_t;

  typedef struct {
    int          due;
    logic [15:0] data;
  } rd_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  cache_fill_responder_if #(.WORDS_PER_BLOCK(W)) bus ();

`ifdef FILL_PERF_CNT_EN
  logic [15:0] i_fill_cnt;
  logic [15:0] d_fill_cnt;
`endif

  cache_fill_responder #(.WORDS_PER_BLOCK(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef FILL_PERF_CNT_EN
    ,
    .i_fill_cnt (i_fill_cnt),
    .d_fill_cnt (d_fill_cnt)
`endif
  );

  always #5 clk = ~clk;

  ov_t         exp_q [RING];
  rd_t         rdq [$];
  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;
  int          free_at = 0;
  bit          chk_en = 1'b0;
  logic [15:0] m_icnt = '0;
  logic [15:0] m_dcnt = '0;

  logic        rst_nx = 1'b1;
  logic        i_pend = 1'b0;
  logic        d_mpend = 1'b0;
  logic        d_spend = 1'b0;
  logic [15:0] i_a = '0;
  logic [15:0] d_a = '0;
  logic [15:0] d_w = '0;

  function automatic logic [15:0] memdata(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  function automatic logic [15:0] sat16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %h, required %h", name, cyc, act, req);
    end
  endtask

  // Expected timeline of one block fill starting at cycle e.
  task automatic sched_fill(input bit is_d, input logic [15:0] a, input int e);
    logic [15:0] b;
    int idx;
    b = a & ~16'(2 * W - 1);
    for (int k = 0; k < W; k++) begin
      idx = (e + k) % RING;
      exp_q[idx].mem_enable = 1'b1;
      exp_q[idx].mem_addr   = b + 16'(2 * k);
      idx = (e + MEM_LATENCY + k) % RING;
      exp_q[idx].fill_data = memdata(b + 16'(2 * k));
      exp_q[idx].word_num  = 3'(k);
      exp_q[idx].iwd       = !is_d;
      exp_q[idx].dwd       = is_d;
    end
    for (int k = 0; k <= MEM_LATENCY + W; k++) exp_q[(e + k) % RING].busy = 1'b1;
    idx = (e + MEM_LATENCY + W) % RING;
    exp_q[idx].iwt = !is_d;
    exp_q[idx].dwt = is_d;
    free_at = e + MEM_LATENCY + W + 1;
  endtask

  task automatic sched_store(input logic [15:0] a, input logic [15:0] wd, input int s);
    int idx;
    idx = s % RING;
    exp_q[idx].mem_enable  = 1'b1;
    exp_q[idx].mem_wr      = 1'b1;
    exp_q[idx].mem_addr    = a;
    exp_q[idx].mem_data_in = wd;
    exp_q[idx].sdone       = 1'b1;
    exp_q[idx].busy        = 1'b1;
    free_at = s + 1;
  endtask

  // One clock cycle: drive inputs, let outputs settle, compare, advance model.
  task automatic step();
    ov_t act;
    int  idx;
    @(posedge clk);
    cyc++;
    #1;
    rst         = rst_nx;
    bus.i_miss  = i_pend;
    bus.i_addr  = i_a;
    bus.d_miss  = d_mpend;
    bus.d_store = d_spend;
    bus.d_addr  = d_a;
    bus.d_wdata = d_w;
    if (rdq.size() > 0 && rdq[0].due == cyc) begin
      bus.mem_data_valid = 1'b1;
      bus.mem_data_out   = rdq[0].data;
      void'(rdq.pop_front());
    end else begin
      bus.mem_data_valid = 1'b0;
      bus.mem_data_out   = 16'($urandom);
    end
    @(negedge clk);
    idx = cyc % RING;
    if (chk_en) begin
      act = '{bus.mem_addr, bus.mem_enable, bus.mem_wr, bus.mem_data_in, bus.fill_data,
              bus.word_num, bus.i_write_data, bus.i_write_tag, bus.d_write_data,
              bus.d_write_tag, bus.d_store_done, bus.busy};
      check("outputs", 32'(act ^ exp_q[idx]), 32'h0);
      if (act !== exp_q[idx])
        $display("     cycle %0d outputs got %h required %h", cyc, act, exp_q[idx]);
`ifdef FILL_PERF_CNT_EN
      check("i_fill_cnt", {16'h0, i_fill_cnt}, {16'h0, m_icnt});
      check("d_fill_cnt", {16'h0, d_fill_cnt}, {16'h0, m_dcnt});
`endif
    end
    if (bus.mem_enable === 1'b1 && bus.mem_wr === 1'b0)
      rdq.push_back('{due: cyc + MEM_LATENCY, data: memdata(bus.mem_addr)});
    if (rst) begin
      m_icnt = '0;
      m_dcnt = '0;
    end else begin
      if (exp_q[idx].iwt) m_icnt = sat16(m_icnt);
      if (exp_q[idx].dwt) m_dcnt = sat16(m_dcnt);
    end
    if (rst) begin
      for (int k = 1; k < 20; k++) exp_q[(cyc + k) % RING] = '0;
      free_at = cyc + 1;
    end else if (cyc >= free_at) begin
      if (bus.d_store && !bus.d_miss) sched_store(bus.d_addr, bus.d_wdata, cyc + 1);
      else if (bus.d_miss)            sched_fill(1'b1, bus.d_addr, cyc + 1);
      else if (bus.i_miss)            sched_fill(1'b0, bus.i_addr, cyc + 1);
    end
    exp_q[idx] = '0;
    if (rst) chk_en = 1'b1;
    if (bus.i_write_tag === 1'b1)  i_pend  = 1'b0;
    if (bus.d_write_tag === 1'b1)  d_mpend = 1'b0;
    if (bus.d_store_done === 1'b1) d_spend = 1'b0;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) step();
  endtask

  initial begin
    int e;
    int s;
    bit wr_early;
    bit tag_seen;
    for (int k = 0; k < RING; k++) exp_q[k] = '0;
    bus.mem_data_valid = 1'b0;
    bus.mem_data_out   = '0;

    // Reset state
    repeat (3) step();
    rst_nx = 1'b0;
    step();
    check("reset_busy", {31'h0, bus.busy}, 32'h0);
    check("reset_mem_enable", {31'h0, bus.mem_enable}, 32'h0);
    check("reset_word_num", {29'h0, bus.word_num}, 32'h0);

    // I fill from 0x0046
    i_a = 16'h0046; i_pend = 1'b1;
    step();
    e = cyc + 1;
    run_to(e);      check("i_first_addr", {16'h0, bus.mem_addr}, 32'h0040);
    run_to(e + 4);  check("i_w0_strobe", {31'h0, bus.i_write_data}, 32'h1);
                    check("i_w0_data", {16'h0, bus.fill_data}, 32'h1A3C);
    run_to(e + 7);  check("i_last_addr", {16'h0, bus.mem_addr}, 32'h004E);
    run_to(e + 11); check("i_w7_num", {29'h0, bus.word_num}, 32'h7);
                    check("i_w7_data", {16'h0, bus.fill_data}, 32'h143C);
    run_to(e + 12); check("i_tag", {31'h0, bus.i_write_tag}, 32'h1);
                    check("i_tag_no_d", {31'h0, bus.d_write_tag}, 32'h0);
    run_to(e + 14);

    // Simultaneous I and D miss: D first, then I
    i_a = 16'h0200; d_a = 16'h1234; i_pend = 1'b1; d_mpend = 1'b1;
    step();
    e = cyc + 1;
    run_to(e);      check("d_first_addr", {16'h0, bus.mem_addr}, 32'h1230);
    run_to(e + 4);  check("d_w0_strobe", {31'h0, bus.d_write_data}, 32'h1);
    run_to(e + 12); check("d_tag", {31'h0, bus.d_write_tag}, 32'h1);
    run_to(e + 13); check("idle_after_d_tag", {31'h0, bus.busy}, 32'h0);
    run_to(e + 14); check("i_after_d_addr", {16'h0, bus.mem_addr}, 32'h0200);
                    check("i_after_d_en", {31'h0, bus.mem_enable}, 32'h1);
    run_to(e + 28);

    // Single store
    d_a = 16'h0100; d_w = 16'hBEEF; d_spend = 1'b1;
    step();
    s = cyc + 1;
    run_to(s);
    check("st_wr", {31'h0, bus.mem_wr}, 32'h1);
    check("st_addr", {16'h0, bus.mem_addr}, 32'h0100);
    check("st_data", {16'h0, bus.mem_data_in}, 32'hBEEF);
    check("st_done", {31'h0, bus.d_store_done}, 32'h1);
    step();
    check("st_busy_1cyc", {31'h0, bus.busy}, 32'h0);

    // Store raised in the middle of an I fill
    i_a = 16'h0360; i_pend = 1'b1;
    step();
    e = cyc + 1;
    run_to(e + 5);
    d_a = 16'h0400; d_w = 16'h1357; d_spend = 1'b1;
    wr_early = 1'b0;
    for (int n = 0; n < 40 && bus.d_store_done !== 1'b1; n++) begin
      step();
      if (bus.mem_wr === 1'b1 && cyc <= e + 12) wr_early = 1'b1;
    end
    check("st_wait_no_early_wr", {31'h0, wr_early}, 32'h0);
    check("st_after_tag_cycle", 32'(cyc), 32'(e + 14));
    check("st_mid_data", {16'h0, bus.mem_data_in}, 32'h1357);
    step();

    // Reset after three received words
    i_a = 16'h0A10; i_pend = 1'b1;
    step();
    e = cyc + 1;
    run_to(e + 6);  check("rst_third_word", {29'h0, bus.word_num}, 32'h2);
    rst_nx = 1'b1; i_pend = 1'b0;
    step();
    rst_nx = 1'b0;
    step();
    check("rst_mid_busy", {31'h0, bus.busy}, 32'h0);
    check("rst_mid_enable", {31'h0, bus.mem_enable}, 32'h0);
    tag_seen = 1'b0;
    while (cyc < e + 16) begin
      step();
      if (bus.i_write_tag === 1'b1 || bus.i_write_data === 1'b1) tag_seen = 1'b1;
    end
    check("rst_no_tag_no_stale", {31'h0, tag_seen}, 32'h0);
    i_pend = 1'b1;
    step();
    e = cyc + 1;
    run_to(e + 4);
    check("refill_w0_num", {29'h0, bus.word_num}, 32'h0);
    check("refill_w0_strobe", {31'h0, bus.i_write_data}, 32'h1);
    check("refill_w0_data", {16'h0, bus.fill_data}, 32'h4A36);
    run_to(e + 14);

    // Address wrap right after a fresh reset
    rst_nx = 1'b1; i_pend = 1'b0; d_mpend = 1'b0; d_spend = 1'b0;
    step(); step();
    rst_nx = 1'b0;
    step();
    i_a = 16'hFFFA; i_pend = 1'b1;
    step();
    e = cyc + 1;
    run_to(e);      check("wrap_first_addr", {16'h0, bus.mem_addr}, 32'hFFF0);
    run_to(e + 7);  check("wrap_last_addr", {16'h0, bus.mem_addr}, 32'hFFFE);
    run_to(e + 13);
`ifdef FILL_PERF_CNT_EN
    check("perf_i_after_wrap", {16'h0, i_fill_cnt}, 32'h1);
    check("perf_d_after_wrap", {16'h0, d_fill_cnt}, 32'h0);
`endif

    // Random traffic from both caches
    for (int n = 0; n < 1500; n++) begin
      if (!i_pend && bus.i_miss === 1'b0) begin
        i_a = 16'($urandom);
        if ($urandom_range(0, 7) == 0) i_a = 16'hFFF0 | 16'($urandom_range(0, 15));
        if ($urandom_range(0, 5) == 0) i_pend = 1'b1;
      end
      if (!d_mpend && !d_spend && bus.d_miss === 1'b0 && bus.d_store === 1'b0) begin
        d_a = 16'($urandom);
        d_w = 16'($urandom);
        case ($urandom_range(0, 9))
          0:       d_mpend = 1'b1;
          1:       d_spend = 1'b1;
          default: ;
        endcase
      end
      step();
    end
    for (int n = 0; n < 40; n++) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
